// File: rtl/reg_wb_ctrl.sv
// rtl/reg_wb_ctrl.sv - register-file write-back arbiter with ALU write buffer, load squash and forwarding
module reg_wb_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_alu_valid,
    input  logic [2:0] i_alu_addr,
    input  logic [7:0] i_alu_data,
    input  logic       i_ld_valid,
    input  logic [7:0] i_ld_data,
    input  logic [2:0] i_rd_addr,
    output logic       o_stall,
    output logic       o_wr_en,
    output logic       o_mem_to_reg,
    output logic [2:0] o_wr_addr,
    output logic [7:0] o_dat_out,
    output logic       o_fwd_hit,
    output logic [7:0] o_fwd_data,
    output logic [7:0] o_drop_cnt
);

    localparam int CW = $clog2(DEPTH + 1);

    // Buffer is kept compacted: entries 0..r_count-1 are valid, index 0 is oldest.
    logic [CW-1:0] r_count;
    logic [2:0]    r_buf_addr [DEPTH];
    logic [7:0]    r_buf_data [DEPTH];
    logic          r_wr_en;
    logic          r_mem_to_reg;
    logic [2:0]    r_wr_addr;
    logic [7:0]    r_dat_out;
    logic [7:0]    r_drop_cnt;

    logic          w_alu_acc;
    logic          w_alu_low;
    logic          w_alu_sq;
    logic          w_alu_live;
    logic          w_pop;
    logic          w_issue_ld;
    logic          w_issue_alu;
    logic [2:0]    w_issue_addr;
    logic [7:0]    w_issue_data;
    logic [2:0]    w_nxt_addr [DEPTH];
    logic [7:0]    w_nxt_data [DEPTH];
    int            w_nxt_cnt;
    int            w_sq_cnt;
    int            w_drop_sum;
    logic [7:0]    w_drop_nxt;

    assign o_stall      = (r_count == CW'(DEPTH));
    assign o_wr_en      = r_wr_en;
    assign o_mem_to_reg = r_mem_to_reg;
    assign o_wr_addr    = r_wr_addr;
    assign o_dat_out    = r_dat_out;
    assign o_drop_cnt   = r_drop_cnt;

    always_comb begin
        w_alu_acc  = i_alu_valid && !o_stall;
        w_alu_low  = w_alu_acc && (i_alu_addr < 3'd2);
        w_alu_sq   = w_alu_acc && i_ld_valid && (i_alu_addr == 3'd2);
        w_alu_live = w_alu_acc && !w_alu_low && !w_alu_sq;
        w_pop      = !i_ld_valid && (r_count != '0);

        w_issue_ld   = i_ld_valid;
        w_issue_alu  = !i_ld_valid && (w_pop || w_alu_live);
        w_issue_addr = 3'd2;
        w_issue_data = i_ld_data;
        if (!i_ld_valid) begin
            if (w_pop) begin
                w_issue_addr = r_buf_addr[0];
                w_issue_data = r_buf_data[0];
            end else begin
                w_issue_addr = i_alu_addr;
                w_issue_data = i_alu_data;
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            w_nxt_addr[i] = 3'd0;
            w_nxt_data[i] = 8'd0;
        end
        w_nxt_cnt = 0;
        w_sq_cnt  = 0;
        // Squashed r2 entries and the popped head are removed while survivors shift down in order.
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(r_count)) begin
                if (i_ld_valid && (r_buf_addr[i] == 3'd2)) begin
                    w_sq_cnt = w_sq_cnt + 1;
                end else if (!(w_pop && (i == 0))) begin
                    w_nxt_addr[w_nxt_cnt] = r_buf_addr[i];
                    w_nxt_data[w_nxt_cnt] = r_buf_data[i];
                    w_nxt_cnt = w_nxt_cnt + 1;
                end
            end
        end
        if (w_alu_live && (i_ld_valid || w_pop)) begin
            w_nxt_addr[w_nxt_cnt] = i_alu_addr;
            w_nxt_data[w_nxt_cnt] = i_alu_data;
            w_nxt_cnt = w_nxt_cnt + 1;
        end

        w_drop_sum = int'(r_drop_cnt) + w_sq_cnt + int'(w_alu_low) + int'(w_alu_sq);
        w_drop_nxt = (w_drop_sum > 255) ? 8'hFF : 8'(w_drop_sum);
    end

    // Younger matches overwrite older ones, so the youngest buffered write wins over the output stage.
    always_comb begin
        o_fwd_hit  = 1'b0;
        o_fwd_data = 8'd0;
        if (i_rd_addr >= 3'd2) begin
            if ((r_wr_en || r_mem_to_reg) && (r_wr_addr == i_rd_addr)) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = r_dat_out;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((i < int'(r_count)) && (r_buf_addr[i] == i_rd_addr)) begin
                    o_fwd_hit  = 1'b1;
                    o_fwd_data = r_buf_data[i];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count      <= '0;
            r_wr_en      <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_wr_addr    <= 3'd0;
            r_dat_out    <= 8'd0;
            r_drop_cnt   <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_addr[i] <= 3'd0;
                r_buf_data[i] <= 8'd0;
            end
        end else begin
            r_count      <= CW'(w_nxt_cnt);
            r_wr_en      <= w_issue_alu;
            r_mem_to_reg <= w_issue_ld;
            r_drop_cnt   <= w_drop_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_addr[i] <= w_nxt_addr[i];
                r_buf_data[i] <= w_nxt_data[i];
            end
            if (w_issue_ld || w_issue_alu) begin
                r_wr_addr <= w_issue_addr;
                r_dat_out <= w_issue_data;
            end
        end
    end

endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 Parameter: DEPTH, default 2, number of pending ALU write-buffer entries (legal 1..4).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock, shared with the register file.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 alu_valid  in  1  ALU result write request.
REQ-006 alu_addr  in  3  ALU destination register.
REQ-007 alu_data  in  8  ALU result.
REQ-008 ld_valid  in  1  load result write request; destination is always r2.
REQ-009 ld_data  in  8  load data.
REQ-010 rd_addr  in  3  forwarding lookup address.
REQ-011 stall  out  1  buffer full; ALU source holds alu_valid/addr/data.
REQ-012 wr_en, MemtoReg  out  1 each  register-file write strobes (registered).
REQ-013 wr_addr  out  3;  dat_out  out  8  register-file write address and data (registered).
REQ-014 fwd_hit  out  1;  fwd_data  out  8  combinational forwarding result.
REQ-015 drop_cnt  out  8  saturating count of discarded ALU writes.

Function
REQ-016 Write issue: at most one register-file write per cycle; outputs registered, write appears the cycle after issue selection and commits at the following edge.
REQ-017 Issue priority per cycle: accepted load > oldest valid buffer entry > same-cycle ALU request (bypass when buffer empty).
REQ-018 Load issue: MemtoReg=1, wr_en=0, wr_addr=2, dat_out=ld_data; ALU issue: wr_en=1, MemtoReg=0.
REQ-019 Idle cycle: wr_en=0, MemtoReg=0; wr_addr/dat_out hold last value.
REQ-020 ALU accept when alu_valid=1 and stall=0; if not issued the same cycle, enqueue at tail (FIFO order).
REQ-021 stall = (valid entry count == DEPTH), from registered state only; a drain in the current cycle does not clear stall until the next cycle.
REQ-022 ALU writes to r0 or r1 SHALL be accepted but discarded (never buffered or issued), incrementing drop_cnt.
REQ-023 Load squash: on accepted load, every valid buffered entry with address 2 is invalidated; a same-cycle ALU request to r2 is discarded; each squash/discard increments drop_cnt (saturating add of the total).
REQ-024 Invalidated entries are skipped at drain and do not count toward stall; FIFO compacts so order of survivors is preserved.
REQ-025 drop_cnt saturates at 255.
REQ-026 Forwarding: fwd_hit=1 if rd_addr matches a valid buffer entry or the output stage currently presenting a write; search order youngest buffer entry -> oldest -> output stage; fwd_data = first match, else 0.
REQ-027 rd_addr 0 or 1 SHALL never hit.
REQ-028 Same-cycle ALU request is not visible to forwarding until registered.

Reset
REQ-029 rst_n low SHALL immediately clear: buffer valids, wr_en, MemtoReg, wr_addr, dat_out, stall, drop_cnt (all 0); fwd_hit=0.
REQ-030 Reset mid-operation discards all pending writes; no write strobe asserts during reset or in the first cycle after release unless a request arrives.

Verification
REQ-031 Empty, alu_valid r3=0x5A -> next cycle wr_en=1, wr_addr=3, dat_out=0x5A; stall=0.
REQ-032 ld_valid 0x11 and alu_valid r5=0x22 same cycle -> cycle+1 MemtoReg=1 addr 2 data 0x11; cycle+2 wr_en=1 addr 5 data 0x22.
REQ-033 DEPTH=2, three back-to-back loads with ALU r4,r6,r7 -> stall=1 after two buffered, r7 held and issued after drain; order r4,r6,r7.
REQ-034 Buffered ALU r2=0x33 then ld_valid 0x44 -> entry squashed, only load written, drop_cnt=1; ALU to r0 -> drop_cnt=2.
REQ-035 Buffer holds r5=0x10 then r5=0x20, rd_addr=5 -> fwd_hit=1, fwd_data=0x20; rd_addr=1 -> fwd_hit=0.
REQ-036 rst_n asserted with two pending entries -> outputs 0 immediately, no writes issued after release.
